// File: rtl/legv8_multicycle_ctrl_if.sv
// rtl/legv8_multicycle_ctrl_if.sv - opcode/status inputs and datapath control points of the LEGv8 multicycle control unit
interface legv8_multicycle_ctrl_if #(
  parameter int OP_W = 11
);
  logic [OP_W-1:0] Op;
  logic            ZeroFlag;
  logic            MemReady;
  logic            Reg2Loc;
  logic            ALUSrc;
  logic            MemtoReg;
  logic            RegWrite;
  logic            MemRead;
  logic            MemWrite;
  logic            Branch;
  logic [1:0]      ALUOp;
  logic            PCWrite;
  logic            IRWrite;
  logic            InstrDone;
  logic            Exc;
  logic [1:0]      ExcCode;
  logic [3:0]      State;

  modport master (
    input  Op, ZeroFlag, MemReady,
    output Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
           ALUOp, PCWrite, IRWrite, InstrDone, Exc, ExcCode, State
  );

  modport slave (
    output Op, ZeroFlag, MemReady,
    input  Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
           ALUOp, PCWrite, IRWrite, InstrDone, Exc, ExcCode, State
  );
endinterface

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - LEGv8 multicycle control FSM with memory timeout and undefined-opcode trap (optional ADDI/SUBI: LEGV8_MC_IMM_OPS_EN)
module legv8_multicycle_ctrl #(
  parameter int OP_W        = 11,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  legv8_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_RWB      = 4'd5,
    S_MEMADDR  = 4'd6,
    S_MEMREAD  = 4'd7,
    S_MEMWB    = 4'd8,
    S_MEMWRITE = 4'd9,
    S_BRANCH   = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             is_store;
  logic [1:0]       exc_code;

  // Decode works on the top 11 bits of the opcode field.
  logic [10:0] op11;
  logic        op_ldur;
  logic        op_stur;
  logic        op_cbz;
  logic        op_rtype;
  logic        op_imm;
  logic        timed_out;

  assign op11     = bus.Op[OP_W-1 -: 11];
  assign op_ldur  = (op11 == 11'b11111000010);
  assign op_stur  = (op11 == 11'b11111000000);
  assign op_cbz   = (op11[10:3] == 8'b10110100);
  assign op_rtype = (op11 == 11'b10001011000) || (op11 == 11'b11001011000) ||
                    (op11 == 11'b10001010000) || (op11 == 11'b10101010000);
`ifdef LEGV8_MC_IMM_OPS_EN
  assign op_imm   = (op11[10:1] == 10'b1001000100) || (op11[10:1] == 10'b1101000100);
`else
  assign op_imm   = 1'b0;
`endif

  // A zero MEM_TIMEOUT means the memory wait is unbounded.
  assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Side registers: load/store flag from DECODE, memory wait counter, latched trap cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      is_store <= 1'b0;
      exc_code <= 2'b00;
    end else begin
      if (state == S_DECODE) begin
        is_store <= op_stur;
      end
      if (state == S_MEMADDR) begin
        wait_cnt <= '0;
      end else if ((state == S_MEMREAD || state == S_MEMWRITE) && !bus.MemReady) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (state != S_ERROR && next_state == S_ERROR) begin
        exc_code <= (state == S_DECODE) ? 2'b01 : 2'b10;
      end
    end
  end

  // Next-state selection; MemReady beats the timeout in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (op_ldur || op_stur)  next_state = S_MEMADDR;
        else if (op_cbz)         next_state = S_BRANCH;
        else if (op_rtype)       next_state = S_EXEC_R;
        else if (op_imm)         next_state = S_EXEC_I;
        else                     next_state = S_ERROR;
      end
      S_EXEC_R: next_state = S_RWB;
`ifdef LEGV8_MC_IMM_OPS_EN
      S_EXEC_I: next_state = S_RWB;
`endif
      S_RWB:     next_state = S_FETCH;
      S_MEMADDR: next_state = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (bus.MemReady)   next_state = S_MEMWB;
        else if (timed_out) next_state = S_ERROR;
        else                next_state = S_MEMREAD;
      end
      S_MEMWB: next_state = S_FETCH;
      S_MEMWRITE: begin
        if (bus.MemReady)   next_state = S_FETCH;
        else if (timed_out) next_state = S_ERROR;
        else                next_state = S_MEMWRITE;
      end
      S_BRANCH: next_state = S_FETCH;
      S_ERROR:  next_state = S_ERROR;
      default:  next_state = S_INIT;
    endcase
  end

  logic       reg2loc;
  logic       alu_src;
  logic       mem_to_reg;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       branch;
  logic [1:0] alu_op;
  logic       pc_write;
  logic       ir_write;
  logic       instr_done;
  logic       exc;
  logic [1:0] exc_code_out;

  // Control points from the state register; BRANCH's Branch/PCWrite follow ZeroFlag,
  // and a store completes in the MEMWRITE cycle that sees MemReady.
  always_comb begin
    reg2loc      = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    alu_op       = 2'b00;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    instr_done   = 1'b0;
    exc          = 1'b0;
    exc_code_out = 2'b00;
    case (state)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_EXEC_R: alu_op = 2'b10;
`ifdef LEGV8_MC_IMM_OPS_EN
      S_EXEC_I: begin
        alu_src = 1'b1;
        alu_op  = 2'b10;
      end
`endif
      S_RWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMADDR: begin
        alu_src = 1'b1;
        reg2loc = is_store;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        alu_src  = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write  = 1'b1;
        reg2loc    = 1'b1;
        alu_src    = 1'b1;
        instr_done = bus.MemReady;
      end
      S_BRANCH: begin
        reg2loc    = 1'b1;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        branch     = bus.ZeroFlag;
        pc_write   = bus.ZeroFlag;
      end
      S_ERROR: begin
        exc          = 1'b1;
        exc_code_out = exc_code;
      end
      default: ;
    endcase
  end

  assign bus.Reg2Loc   = reg2loc;
  assign bus.ALUSrc    = alu_src;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.RegWrite  = reg_write;
  assign bus.MemRead   = mem_read;
  assign bus.MemWrite  = mem_write;
  assign bus.Branch    = branch;
  assign bus.ALUOp     = alu_op;
  assign bus.PCWrite   = pc_write;
  assign bus.IRWrite   = ir_write;
  assign bus.InstrDone = instr_done;
  assign bus.Exc       = exc;
  assign bus.ExcCode   = exc_code_out;
  assign bus.State     = state;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb/tb_legv8_multicycle_ctrl.sv - self-checking bench for legv8_multicycle_ctrl
module tb_legv8_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  legv8_multicycle_ctrl_if #(.OP_W(11)) ifc_a ();
  legv8_multicycle_ctrl_if #(.OP_W(11)) ifc_b ();

  legv8_multicycle_ctrl #(.OP_W(11), .MEM_TIMEOUT(16), .CNT_W(5)) dut_a (
    .clk(clk), .reset(reset), .bus(ifc_a.master)
  );
  legv8_multicycle_ctrl #(.OP_W(11), .MEM_TIMEOUT(0), .CNT_W(5)) dut_b (
    .clk(clk), .reset(reset), .bus(ifc_b.master)
  );

  // Output vector: {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
  //                 ALUOp[1:0], PCWrite, IRWrite, InstrDone, Exc, ExcCode[1:0]}
  localparam logic [14:0] V_R2L   = 15'h4000;
  localparam logic [14:0] V_ASRC  = 15'h2000;
  localparam logic [14:0] V_M2R   = 15'h1000;
  localparam logic [14:0] V_RW    = 15'h0800;
  localparam logic [14:0] V_MR    = 15'h0400;
  localparam logic [14:0] V_MW    = 15'h0200;
  localparam logic [14:0] V_BR    = 15'h0100;
  localparam logic [14:0] V_AOP10 = 15'h0080;
  localparam logic [14:0] V_AOP01 = 15'h0040;
  localparam logic [14:0] V_PCW   = 15'h0020;
  localparam logic [14:0] V_IRW   = 15'h0010;
  localparam logic [14:0] V_DONE  = 15'h0008;
  localparam logic [14:0] V_EXC   = 15'h0004;
  localparam logic [14:0] V_UNDEF = 15'h0001;
  localparam logic [14:0] V_TMO   = 15'h0002;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;

`ifdef LEGV8_MC_IMM_OPS_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_UNDEF = 5;

  typedef struct {
    logic [14:0] ea;
    logic [14:0] eb;
    int          pin_len;
    int          pin_mr;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   len_ctr = 0;
  int   mr_ctr = 0;

  logic [14:0] act_a, act_b;
  assign act_a = {ifc_a.Reg2Loc, ifc_a.ALUSrc, ifc_a.MemtoReg, ifc_a.RegWrite, ifc_a.MemRead,
                  ifc_a.MemWrite, ifc_a.Branch, ifc_a.ALUOp, ifc_a.PCWrite, ifc_a.IRWrite,
                  ifc_a.InstrDone, ifc_a.Exc, ifc_a.ExcCode};
  assign act_b = {ifc_b.Reg2Loc, ifc_b.ALUSrc, ifc_b.MemtoReg, ifc_b.RegWrite, ifc_b.MemRead,
                  ifc_b.MemWrite, ifc_b.Branch, ifc_b.ALUOp, ifc_b.PCWrite, ifc_b.IRWrite,
                  ifc_b.InstrDone, ifc_b.Exc, ifc_b.ExcCode};

  function automatic int classify(input logic [10:0] op);
    casez (op)
      11'b11111000010: return K_LD;
      11'b11111000000: return K_ST;
      11'b10110100???: return K_BR;
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: return K_R;
      11'b1001000100?, 11'b1101000100?: return IMM_EN ? K_I : K_UNDEF;
      default: return K_UNDEF;
    endcase
  endfunction

  // Per-cycle checker: outputs of both units against the queued expectation,
  // plus instruction length / MemRead count pins on flagged cycles.
  always @(negedge clk) begin
    if (expq.size() != 0) begin
      e = expq.pop_front();
      cyc++;
      if (act_a[4]) begin
        len_ctr = 1;
        mr_ctr  = int'(act_a[10]);
      end else begin
        len_ctr++;
        mr_ctr += int'(act_a[10]);
      end
      tests++;
      if (act_a !== e.ea) begin
        fails++;
        $display("FAIL ctl_a cyc=%0d act=%h exp=%h", cyc, act_a, e.ea);
      end
      tests++;
      if (act_b !== e.eb || (e.ea == e.eb && ifc_a.State !== ifc_b.State)) begin
        fails++;
        $display("FAIL ctl_b cyc=%0d act=%h exp=%h state_a=%0d state_b=%0d",
                 cyc, act_b, e.eb, ifc_a.State, ifc_b.State);
      end
      if (e.pin_len != 0) begin
        tests++;
        if (len_ctr != e.pin_len) begin
          fails++;
          $display("FAIL instr_len cyc=%0d act=%0d exp=%0d", cyc, len_ctr, e.pin_len);
        end
      end
      if (e.pin_mr >= 0) begin
        tests++;
        if (mr_ctr != e.pin_mr) begin
          fails++;
          $display("FAIL memread_cycles cyc=%0d act=%0d exp=%0d", cyc, mr_ctr, e.pin_mr);
        end
      end
    end
  end

  task automatic step(input bit rst, input logic [10:0] op, input bit zero, input bit rdy,
                      input logic [14:0] ea, input logic [14:0] eb, input int pl, input int pm);
    exp_t x;
    @(posedge clk);
    #1;
    reset          = rst;
    ifc_a.Op       = op;
    ifc_b.Op       = op;
    ifc_a.ZeroFlag = zero;
    ifc_b.ZeroFlag = zero;
    ifc_a.MemReady = rdy;
    ifc_b.MemReady = rdy;
    x.ea = ea;
    x.eb = eb;
    x.pin_len = pl;
    x.pin_mr = pm;
    expq.push_back(x);
  endtask

  task automatic s(input logic [10:0] op, input bit zero, input bit rdy, input logic [14:0] ev);
    step(1'b0, op, zero, rdy, ev, ev, 0, -1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 11'd0, 1'b0, 1'b0, 15'h0, 15'h0, 0, -1);
    step(1'b0, 11'd0, 1'b0, 1'b0, 15'h0, 15'h0, 0, -1);
  endtask

  // One instruction from FETCH to its last cycle; w = cycles with MemReady low.
  task automatic run_instr(input logic [10:0] op, input bit zero, input int w,
                           input int pl, input int pm);
    logic [14:0] ev;
    s(op, zero, 1'b0, V_IRW | V_PCW);
    s(op, zero, 1'b0, 15'h0);
    case (classify(op))
      K_R: begin
        s(op, zero, 1'b0, V_AOP10);
        step(1'b0, op, zero, 1'b0, V_RW | V_DONE, V_RW | V_DONE, pl, pm);
      end
      K_I: begin
        s(op, zero, 1'b0, V_ASRC | V_AOP10);
        step(1'b0, op, zero, 1'b0, V_RW | V_DONE, V_RW | V_DONE, pl, pm);
      end
      K_LD: begin
        s(op, zero, 1'b0, V_ASRC);
        for (int i = 0; i < w; i++) s(op, zero, 1'b0, V_MR | V_ASRC);
        s(op, zero, 1'b1, V_MR | V_ASRC);
        step(1'b0, op, zero, 1'b0, V_M2R | V_RW | V_DONE, V_M2R | V_RW | V_DONE, pl, pm);
      end
      K_ST: begin
        s(op, zero, 1'b0, V_ASRC | V_R2L);
        for (int i = 0; i < w; i++) s(op, zero, 1'b0, V_MW | V_R2L | V_ASRC);
        ev = V_MW | V_R2L | V_ASRC | V_DONE;
        step(1'b0, op, zero, 1'b1, ev, ev, pl, pm);
      end
      K_BR: begin
        ev = V_R2L | V_AOP01 | V_DONE | (zero ? (V_BR | V_PCW) : 15'h0);
        step(1'b0, op, zero, 1'b0, ev, ev, pl, pm);
      end
      default: begin
        for (int i = 0; i < 4; i++) s(op, zero, 1'b0, V_EXC | V_UNDEF);
      end
    endcase
  endtask

  initial begin
    ifc_a.Op = '0;  ifc_b.Op = '0;
    ifc_a.ZeroFlag = 1'b0; ifc_b.ZeroFlag = 1'b0;
    ifc_a.MemReady = 1'b0; ifc_b.MemReady = 1'b0;

    do_reset();

    run_instr(OP_ADD, 1'b0, 0, 4, -1);
    run_instr(OP_SUB, 1'b1, 0, 4, -1);
    run_instr(OP_AND, 1'b0, 0, 0, -1);
    run_instr(OP_ORR, 1'b0, 0, 0, -1);
    run_instr(OP_LDUR, 1'b0, 3, 8, 4);
    run_instr(OP_LDUR, 1'b0, 0, 5, 1);
    run_instr(OP_STUR, 1'b0, 2, 6, 0);
    run_instr(OP_STUR, 1'b1, 0, 4, 0);
    run_instr(OP_CBZ, 1'b1, 0, 3, -1);
    run_instr(OP_CBZ, 1'b0, 0, 3, -1);
    run_instr(OP_LDUR, 1'b0, 16, 21, 17);

    // ADDI: immediate path when enabled, otherwise an undefined-opcode trap.
    run_instr(OP_ADDI, 1'b0, 0, IMM_EN ? 4 : 0, -1);
    do_reset();

    // STUR with MemReady stuck low: bounded unit traps, unbounded one keeps waiting.
    s(OP_STUR, 1'b0, 1'b0, V_IRW | V_PCW);
    s(OP_STUR, 1'b0, 1'b0, 15'h0);
    s(OP_STUR, 1'b0, 1'b0, V_ASRC | V_R2L);
    for (int i = 0; i < 17; i++) s(OP_STUR, 1'b0, 1'b0, V_MW | V_R2L | V_ASRC);
    for (int i = 0; i < 20; i++)
      step(1'b0, OP_STUR, 1'b0, 1'b0, V_EXC | V_TMO, V_MW | V_R2L | V_ASRC, 0, -1);
    do_reset();

    // Reset asserted during a MEMREAD wait.
    s(OP_LDUR, 1'b0, 1'b0, V_IRW | V_PCW);
    s(OP_LDUR, 1'b0, 1'b0, 15'h0);
    s(OP_LDUR, 1'b0, 1'b0, V_ASRC);
    for (int i = 0; i < 3; i++) s(OP_LDUR, 1'b0, 1'b0, V_MR | V_ASRC);
    do_reset();
    run_instr(OP_ADD, 1'b0, 0, 4, -1);

    // Undefined opcode.
    run_instr(11'd0, 1'b0, 0, 0, -1);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
